ifetch_unit: RTL and testbench



---
 rtl/ifetch_unit.sv | 143 ++++++++++++++
 tb/tb_ifetch_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches with a credit limit of two,
// buffers in-order responses in a 2-entry FIFO and flushes wrong-path traffic on redirect.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends on ready, and a response cannot be back-pressured.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  drop_cnt_q, drop_cnt_d;

  logic [31:0] aq_q [2];
  logic        aq_rd_q, aq_wr_q;

  logic [31:0] fifo_inst_q [2];
  logic [31:0] fifo_pc_q [2];
  logic        fifo_rd_q, fifo_wr_q;
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;

  logic        accept, pop, resp_run;
  logic [2:0]  credit_used;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    inst_valid     = (fifo_cnt_q != 2'd0) && !redirect_valid;
    pop            = inst_valid && inst_ready;
    // A slot freed by this cycle's pop can be reused by this cycle's request.
    credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q} - {2'b00, pop};
    imem_req_valid = (state_q == ST_RUN) && !redirect_valid && (credit_used < 3'd2);
    imem_req_addr  = pc_q;
    accept         = imem_req_valid && imem_req_ready;
    resp_run       = imem_resp_valid && (state_q == ST_RUN) && !redirect_valid;
    inst           = fifo_inst_q[fifo_rd_q];
    inst_pc        = fifo_pc_q[fifo_rd_q];

    outstanding_d = outstanding_q;
    if (accept && !imem_resp_valid) begin
      outstanding_d = outstanding_q + 2'd1;
    end else if (!accept && imem_resp_valid && (outstanding_q != 2'd0)) begin
      outstanding_d = outstanding_q - 2'd1;
    end

    // A response landing in the redirect cycle is itself wrong-path and already gone.
    drop_cnt_d = outstanding_q;
    if (imem_resp_valid && (outstanding_q != 2'd0)) begin
      drop_cnt_d = outstanding_q - 2'd1;
    end

    fifo_cnt_d = fifo_cnt_q;
    if (resp_run && !pop) begin
      fifo_cnt_d = fifo_cnt_q + 2'd1;
    end else if (!resp_run && pop) begin
      fifo_cnt_d = fifo_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pc_q           <= RESET_PC;
      outstanding_q  <= 2'd0;
      drop_cnt_q     <= 2'd0;
      aq_q[0]        <= 32'd0;
      aq_q[1]        <= 32'd0;
      aq_rd_q        <= 1'b0;
      aq_wr_q        <= 1'b0;
      fifo_inst_q[0] <= 32'd0;
      fifo_inst_q[1] <= 32'd0;
      fifo_pc_q[0]   <= 32'd0;
      fifo_pc_q[1]   <= 32'd0;
      fifo_rd_q      <= 1'b0;
      fifo_wr_q      <= 1'b0;
      fifo_cnt_q     <= 2'd0;
    end else begin
      outstanding_q <= outstanding_d;
      if (redirect_valid) begin
        pc_q       <= {redirect_pc[31:2], 2'b00};
        aq_rd_q    <= 1'b0;
        aq_wr_q    <= 1'b0;
        fifo_rd_q  <= 1'b0;
        fifo_wr_q  <= 1'b0;
        fifo_cnt_q <= 2'd0;
        drop_cnt_q <= drop_cnt_d;
        state_q    <= (drop_cnt_d != 2'd0) ? ST_FLUSH : ST_RUN;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_RUN;
          ST_RUN: begin
            if (accept) begin
              pc_q          <= pc_q + 32'd4;
              aq_q[aq_wr_q] <= pc_q;
              aq_wr_q       <= ~aq_wr_q;
            end
            if (resp_run) begin
              fifo_inst_q[fifo_wr_q] <= imem_resp_data;
              fifo_pc_q[fifo_wr_q]   <= aq_q[aq_rd_q];
              fifo_wr_q              <= ~fifo_wr_q;
              aq_rd_q                <= ~aq_rd_q;
            end
            if (pop) begin
              fifo_rd_q <= ~fifo_rd_q;
            end
            fifo_cnt_q <= fifo_cnt_d;
          end
          ST_FLUSH: begin
            if (imem_resp_valid && (drop_cnt_q != 2'd0)) begin
              drop_cnt_q <= drop_cnt_q - 2'd1;
              if (drop_cnt_q == 2'd1) begin
                state_q <= ST_RUN;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: in-order memory with random latency, stream-level reference model
// of the delivered {pc, inst} sequence, directed scenarios followed by randomized traffic.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  ifetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem_addr_q[$];
  int unsigned mem_due_q[$];

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        mem_addr_q.push_back(imem_req_addr);
        mem_due_q.push_back(cyc + $urandom_range(lat_max, lat_min));
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_addr_q.delete();
        mem_due_q.delete();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
      end else if (mem_addr_q.size() != 0 && mem_due_q[0] <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memfn(mem_addr_q.pop_front());
        void'(mem_due_q.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_req_pc;
  int          out_m;
  logic        prev_stall;
  logic [31:0] prev_inst, prev_pc;

  initial begin
    logic [31:0] e;
    exp_req_pc = RESET_PC;
    out_m      = 0;
    prev_stall = 1'b0;
    prev_inst  = 32'd0;
    prev_pc    = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_req_pc = RESET_PC;
        out_m      = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && inst_valid) begin
          check32("hold_inst", inst, prev_inst);
          check32("hold_pc", inst_pc, prev_pc);
        end
        if (redirect_valid) begin
          check1("redir_inst_valid", inst_valid, 1'b0);
          check1("redir_req_valid", imem_req_valid, 1'b0);
        end
        if (imem_req_valid && imem_req_ready) begin
          check32("req_addr", imem_req_addr, exp_req_pc);
          check1("credit_limit", out_m < 2, 1'b1);
          exp_q.push_back(exp_req_pc);
          exp_req_pc = exp_req_pc + 32'd4;
          out_m++;
        end
        if (imem_resp_valid && out_m > 0) out_m--;
        if (inst_valid && inst_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pop_unexpected: got pc %08h expected no instruction", inst_pc);
          end else begin
            e = exp_q.pop_front();
            check32("inst_pc", inst_pc, e);
            check32("inst_word", inst, memfn(e));
          end
        end
        if (redirect_valid) begin
          exp_q.delete();
          exp_req_pc = {redirect_pc[31:2], 2'b00};
        end
        prev_stall = inst_valid && !inst_ready;
        prev_inst  = inst;
        prev_pc    = inst_pc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_req_valid"}, imem_req_valid, 1'b0);
    check1({tag, "_inst_valid"}, inst_valid, 1'b0);
    check32({tag, "_inst"}, inst, 32'd0);
    check32({tag, "_inst_pc"}, inst_pc, 32'd0);
    check32({tag, "_req_addr"}, imem_req_addr, RESET_PC);
  endtask

  // Records up to n accepted request addresses within a cycle budget.
  task automatic capture_acc(input int n, output logic [31:0] a0, output logic [31:0] a1,
                             output logic [31:0] a2, output int got);
    logic [31:0] acc [3];
    got = 0;
    acc[0] = 32'd0; acc[1] = 32'd0; acc[2] = 32'd0;
    for (int k = 0; k < 60 && got < n; k++) begin
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        acc[got] = imem_req_addr;
        got++;
      end
    end
    a0 = acc[0]; a1 = acc[1]; a2 = acc[2];
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: cycle budget expired without the awaited event", name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        rv [6];
    logic        iv [6];
    logic [31:0] ra [6];
    logic [31:0] ip [6];
    logic [31:0] a0, a1, a2;
    logic [31:0] pp [2];
    int          got;
    bit          found;

    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    lat_min = 1; lat_max = 1;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Startup timing with 1-cycle memory and decode always ready.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rv[k] = imem_req_valid; ra[k] = imem_req_addr;
      iv[k] = inst_valid;     ip[k] = inst_pc;
    end
    check1("idle_no_req", rv[0], 1'b0);
    check1("first_req_valid", rv[1], 1'b1);
    check32("first_req_addr", ra[1], 32'h0);
    check1("second_req_valid", rv[2], 1'b1);
    check32("second_req_addr", ra[2], 32'h4);
    check32("third_req_addr", ra[3], 32'h8);
    check1("inst_not_yet", iv[2], 1'b0);
    check1("first_inst_valid", iv[3], 1'b1);
    check32("first_inst_pc", ip[3], 32'h0);
    check1("second_inst_valid", iv[4], 1'b1);
    check32("second_inst_pc", ip[4], 32'h4);
    check32("third_inst_pc", ip[5], 32'h8);

    // Decode stall for 5 cycles: FIFO fills, requests stop.
    step();
    inst_ready = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check1("stall_req_dropped", imem_req_valid, 1'b0);
    check1("stall_inst_held", inst_valid, 1'b1);
    step();
    inst_ready = 1'b1;
    repeat (10) step();

    // Redirect with two requests in flight on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      #1;
      if (mem_addr_q.size() == 2) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) timeout_fail("two_outstanding");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    got = 0;
    pp[0] = 32'd0; pp[1] = 32'd0;
    for (int k = 0; k < 60 && got < 2; k++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        pp[got] = inst_pc;
        got++;
      end
    end
    if (got < 2) timeout_fail("flush_resume");
    check32("flush_first_pc", pp[0], 32'h100);
    check32("flush_second_pc", pp[1], 32'h104);

    // Redirect in a cycle carrying a response and a would-be pop.
    lat_min = 1; lat_max = 2;
    step();
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      #1;
      if (imem_resp_valid && inst_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) timeout_fail("resp_pop_window");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    @(negedge clk);
    check1("redir_blocks_pop", inst_valid, 1'b0);
    step();
    redirect_valid = 1'b0;
    repeat (12) step();

    // Unaligned redirect target and PC wrap-around.
    lat_min = 1; lat_max = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    step();
    redirect_valid = 1'b0;
    capture_acc(1, a0, a1, a2, got);
    if (got < 1) timeout_fail("align_req");
    check32("aligned_req", a0, 32'h200);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    capture_acc(3, a0, a1, a2, got);
    if (got < 3) timeout_fail("wrap_req");
    check32("wrap_req0", a0, 32'hFFFF_FFF8);
    check32("wrap_req1", a1, 32'hFFFF_FFFC);
    check32("wrap_req2", a2, 32'h0000_0000);
    repeat (8) step();

    // Asynchronous reset pulse mid-stream.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    capture_acc(1, a0, a1, a2, got);
    if (got < 1) timeout_fail("restart_req");
    check32("restart_pc", a0, RESET_PC);
    step();

    // Randomized traffic.
    lat_min = 1; lat_max = 3;
    for (int k = 0; k < 3000; k++) begin
      redirect_valid = 1'b0;
      imem_req_ready = ($urandom_range(99, 0) < 70);
      inst_ready     = ($urandom_range(99, 0) < 75);
      if ($urandom_range(799, 0) == 0) begin
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
      end else if ($urandom_range(29, 0) == 0) begin
        redirect_valid = 1'b1;
        case ($urandom_range(2, 0))
          0: redirect_pc = $urandom;
          1: redirect_pc = 32'hFFFF_FFF0 + $urandom_range(15, 0);
          default: redirect_pc = $urandom_range(32'h0000_0FFF, 0);
        endcase
      end
      step();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    tests++;
    fails++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
